// File: rtl/number_ram_arbiter.sv
// number_ram_arbiter: two-port fixed-priority RAM arbiter with port-1 starvation guard
module number_ram_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic                  gnt0,
  output logic                  rsp_valid0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rsp_valid1,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_i,
  input  logic [DATA_WIDTH-1:0] ram_data_o,
  output logic [15:0]           conflict_cnt
);
  logic [7:0]  starve_cnt_q, starve_cnt_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic        rsp_valid0_q, rsp_valid1_q;
  logic        starve_flag;
  // Grant selection, RAM mux and next-state for the counters
  always_comb begin
    starve_flag    = starve_cnt_q == 8'(STARVE_LIMIT);
    gnt1           = req1 & (~req0 | starve_flag);
    gnt0           = req0 & ~gnt1;
    ram_en         = gnt0 | gnt1;
    ram_we         = gnt1 & we1;
    ram_addr       = gnt1 ? addr1 : gnt0 ? addr0 : '0;
    ram_data_i     = gnt1 ? wdata1 : '0;
    starve_cnt_d   = (req1 & ~gnt1) ? starve_cnt_q + 8'd1 : 8'd0;
    conflict_cnt_d = (req0 & req1 & ~&conflict_cnt_q) ? conflict_cnt_q + 16'd1 : conflict_cnt_q;
  end
  // Response strobes trail the grant by one cycle; reset drops any in-flight response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q   <= '0;
      conflict_cnt_q <= '0;
      rsp_valid0_q   <= 1'b0;
      rsp_valid1_q   <= 1'b0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
      rsp_valid0_q   <= gnt0;
      rsp_valid1_q   <= gnt1;
    end
  end
  assign rsp_valid0   = rsp_valid0_q;
  assign rsp_valid1   = rsp_valid1_q;
  assign rsp_data     = ram_data_o;
  assign conflict_cnt = conflict_cnt_q;
endmodule

// File: tb/tb_number_ram_arbiter.sv
// tb_number_ram_arbiter: directed checks of the arbiter with a behavioural write-first RAM
module tb_number_ram_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [7:0]  wdata1 = '0;
  logic        gnt0, gnt1, rsp_valid0, rsp_valid1, ram_en, ram_we;
  logic [7:0]  rsp_data, ram_data_i;
  logic [7:0]  ram_data_o = '0;
  logic [15:0] ram_addr, conflict_cnt;
  logic [7:0]  mem [0:255];
  int checks = 0;
  int errors = 0;

  number_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rsp_valid0(rsp_valid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rsp_valid1(rsp_valid1),
    .rsp_data(rsp_data), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data_i(ram_data_i), .ram_data_o(ram_data_o), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr[7:0]] <= ram_data_i;
        ram_data_o <= ram_data_i;
      end else begin
        ram_data_o <= mem[ram_addr[7:0]];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    we1 = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 1'b1;
    addr0 = 16'h0010;
    #1;
    checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid0 got %b exp 0", rsp_valid0); end
    checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid1 got %b exp 0", rsp_valid1); end
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL reset_conflict got %h exp 0000", conflict_cnt); end
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL reset_grant_follows_req got %b exp 1", gnt0); end
    tick();
    checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL reset_hold_rsp got %b exp 0", rsp_valid0); end
    req0 = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if ({ram_en, ram_we, ram_addr, ram_data_i} !== 26'd0) begin errors++; $display("FAIL idle_ram_bus got en=%b we=%b a=%h d=%h exp all 0", ram_en, ram_we, ram_addr, ram_data_i); end
    checks++; if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL idle_grants got %b exp 00", {gnt0, gnt1}); end
  endtask

  task automatic test_read();
    do_reset();
    req0 = 1'b1;
    addr0 = 16'h0010;
    #1;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL read_gnt got %b%b exp 10", gnt0, gnt1); end
    checks++; if (ram_en !== 1'b1 || ram_addr !== 16'h0010 || ram_we !== 1'b0) begin errors++; $display("FAIL read_ram_bus got en=%b a=%h we=%b exp 1 0010 0", ram_en, ram_addr, ram_we); end
    tick();
    req0 = 1'b0;
    checks++; if (rsp_valid0 !== 1'b1) begin errors++; $display("FAIL read_rsp_valid0 got %b exp 1", rsp_valid0); end
    checks++; if (rsp_data !== 8'hA5) begin errors++; $display("FAIL read_rsp_data got %h exp a5", rsp_data); end
    tick();
    checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL read_rsp_once got %b exp 0", rsp_valid0); end
  endtask

  task automatic test_write_read();
    do_reset();
    req1 = 1'b1;
    we1 = 1'b1;
    addr1 = 16'h0020;
    wdata1 = 8'h3C;
    #1;
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL write_gnt got %b%b exp 01", gnt0, gnt1); end
    checks++; if (ram_we !== 1'b1 || ram_addr !== 16'h0020 || ram_data_i !== 8'h3C) begin errors++; $display("FAIL write_ram_bus got we=%b a=%h d=%h exp 1 0020 3c", ram_we, ram_addr, ram_data_i); end
    tick();
    we1 = 1'b0;
    wdata1 = 8'h00;
    checks++; if (rsp_valid1 !== 1'b1 || rsp_data !== 8'h3C) begin errors++; $display("FAIL write_rsp got v=%b d=%h exp 1 3c", rsp_valid1, rsp_data); end
    #1;
    checks++; if (ram_we !== 1'b0 || ram_data_i !== 8'h00) begin errors++; $display("FAIL read1_ram_bus got we=%b d=%h exp 0 00", ram_we, ram_data_i); end
    tick();
    req1 = 1'b0;
    checks++; if (rsp_valid1 !== 1'b1 || rsp_data !== 8'h3C) begin errors++; $display("FAIL read1_rsp got v=%b d=%h exp 1 3c", rsp_valid1, rsp_data); end
    checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL read1_no_rsp0 got %b exp 0", rsp_valid0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [0:3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    do_reset();
    we1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0 = 1'b1;
      addr0 = 16'(i + 1);
      #1;
      checks++; if (gnt0 !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL b2b_gnt%0d got g=%b we=%b exp 1 0", i, gnt0, ram_we); end
      tick();
      checks++; if (rsp_valid0 !== 1'b1 || rsp_data !== exp_d[i]) begin errors++; $display("FAIL b2b_rsp%0d got v=%b d=%h exp 1 %h", i, rsp_valid0, rsp_data, exp_d[i]); end
    end
    req0 = 1'b0;
    we1 = 1'b0;
  endtask

  task automatic test_starve();
    logic exp1;
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    addr0 = 16'h0010;
    addr1 = 16'h0020;
    for (int i = 0; i < 32; i++) begin
      exp1 = (i % 16) == 15;
      #1;
      checks++; if (gnt1 !== exp1 || gnt0 !== !exp1) begin errors++; $display("FAIL starve_cycle%0d got %b%b exp %b%b", i, gnt0, gnt1, !exp1, exp1); end
      tick();
      if (exp1) begin
        checks++; if (dut.starve_cnt_q !== 8'd0) begin errors++; $display("FAIL starve_clear%0d got %0d exp 0", i, dut.starve_cnt_q); end
        checks++; if (rsp_valid1 !== 1'b1 || rsp_valid0 !== 1'b0) begin errors++; $display("FAIL starve_rsp%0d got %b%b exp 01", i, rsp_valid0, rsp_valid1); end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_reset_drop();
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    addr0 = 16'h0010;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL drop_gnt got %b exp 1", gnt0); end
    tick();
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    #1;
    checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL drop_rsp_in_reset got %b exp 0", rsp_valid0); end
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL drop_conflict got %h exp 0000", conflict_cnt); end
    checks++; if (dut.starve_cnt_q !== 8'd0) begin errors++; $display("FAIL drop_starve got %0d exp 0", dut.starve_cnt_q); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0) begin errors++; $display("FAIL drop_rsp_after got %b%b exp 00", rsp_valid0, rsp_valid1); end
  endtask

  task automatic test_random();
    logic pg0, pg1;
    do_reset();
    pg0 = 1'b0;
    pg1 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      req0 = 1'($urandom);
      req1 = 1'($urandom);
      we1 = 1'($urandom);
      addr0 = 16'($urandom_range(0, 255));
      addr1 = 16'($urandom_range(0, 255));
      wdata1 = 8'($urandom);
      #1;
      checks++; if ((gnt0 & gnt1) || (gnt0 & !req0) || (gnt1 & !req1) || ((req0 | req1) & !(gnt0 | gnt1))) begin errors++; $display("FAIL rand_gnt%0d got g=%b%b exp legal for r=%b%b", i, gnt0, gnt1, req0, req1); end
      pg0 = gnt0;
      pg1 = gnt1;
      tick();
      checks++; if (rsp_valid0 !== pg0 || rsp_valid1 !== pg1) begin errors++; $display("FAIL rand_rsp%0d got %b%b exp %b%b", i, rsp_valid0, rsp_valid1, pg0, pg1); end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_conflict_sat();
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    repeat (100) tick();
    checks++; if (conflict_cnt !== 16'd100) begin errors++; $display("FAIL conflict_count got %0d exp 100", conflict_cnt); end
    repeat (65440) tick();
    checks++; if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL conflict_sat got %h exp ffff", conflict_cnt); end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h01] = 8'h11;
    mem[8'h02] = 8'h22;
    mem[8'h03] = 8'h33;
    mem[8'h04] = 8'h44;
    mem[8'h10] = 8'hA5;
    #1;
    test_reset();
    test_read();
    test_write_read();
    test_back_to_back();
    test_starve();
    test_reset_drop();
    test_random();
    test_conflict_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/number_ram_arbiter.md
NUMBER_RAM_ARBITER -- requirements
Module: number_ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, shall set the RAM data width.
REQ-002 Parameter ADDR_WIDTH, default 16, shall set the RAM address width.
REQ-003 Parameter STARVE_LIMIT, default 15, shall set the number of consecutive denied cycles after which port 1 gets precedence; legal range 1..255.
REQ-004 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  shall be the asynchronous, active-high reset.
REQ-006 req0  input  1  shall be the port-0 (display pixel fetch) read request.
REQ-007 addr0  input  ADDR_WIDTH  shall be the port-0 read address.
REQ-008 gnt0  output  1  shall be the combinational port-0 grant.
REQ-009 rsp_valid0  output  1  shall be the registered port-0 response strobe.
REQ-010 req1  input  1  shall be the port-1 (score/update logic) request.
REQ-011 we1  input  1  shall mark the port-1 request as a write.
REQ-012 addr1  input  ADDR_WIDTH  shall be the port-1 address.
REQ-013 wdata1  input  DATA_WIDTH  shall be the port-1 write data.
REQ-014 gnt1  output  1  shall be the combinational port-1 grant.
REQ-015 rsp_valid1  output  1  shall be the registered port-1 response strobe.
REQ-016 rsp_data  output  DATA_WIDTH  shall be the shared response data, equal to ram_data_o.
REQ-017 ram_en, ram_we  output  1 each  shall drive the RAM en and we pins.
REQ-018 ram_addr  output  ADDR_WIDTH, ram_data_i  output  DATA_WIDTH  shall drive the RAM address and write data.
REQ-019 ram_data_o  input  DATA_WIDTH  shall be the RAM registered read data (1-cycle latency, write-first).
REQ-020 conflict_cnt  output  16  shall count cycles with req0 and req1 both high.

Function
REQ-021 At most one of gnt0/gnt1 shall be high in any cycle; a grant shall occur only when its req is high.
REQ-022 Default priority: port 0 wins whenever req0 is high, unless starve_flag is set.
REQ-023 starve_cnt (8 bit) shall increment each cycle req1 is high and gnt1 is low, and clear on gnt1 or when req1 is low.
REQ-024 starve_flag shall be high when starve_cnt == STARVE_LIMIT; then port 1 wins that cycle even with req0 high.
REQ-025 ram_en shall equal gnt0|gnt1; ram_addr/ram_we/ram_data_i shall mux from the granted port; with no grant, ram_addr/ram_data_i = 0, ram_we = 0.
REQ-026 Port 0 shall never drive ram_we high.
REQ-027 Requesters shall hold req/addr/we/wdata stable until granted; grant in cycle N completes the handshake.
REQ-028 rsp_valid0/rsp_valid1 shall be high in cycle N+1 exactly for the port granted in cycle N, for reads and writes; latency 1 cycle.
REQ-029 For a port-1 write, rsp_data in cycle N+1 shall equal the written wdata1.
REQ-030 Back-to-back grants shall be permitted every cycle; sustained throughput 1 access per cycle.
REQ-031 conflict_cnt shall saturate at 16'hFFFF.

Reset
REQ-032 While reset is high: rsp_valid0 = rsp_valid1 = 0, starve_cnt = 0, conflict_cnt = 0; grants still follow REQ-022 from inputs.
REQ-033 Reset asserted between a grant and its response shall drop that response (no rsp_valid after reset release).

Verification
REQ-034 req0 only, addr0 = 16'h0010 with RAM[0x10] = 8'hA5 -> gnt0 same cycle, rsp_valid0 = 1 and rsp_data = 8'hA5 next cycle.
REQ-035 req1 we1 = 1 addr1 = 16'h0020 wdata1 = 8'h3C, then read of 16'h0020 -> write rsp_data = 8'h3C, read rsp_data = 8'h3C.
REQ-036 req0 and req1 held high continuously, STARVE_LIMIT = 15 -> gnt0 for 15 cycles, gnt1 on the 16th, starve_cnt back to 0; pattern repeats.
REQ-037 Overlapping requests for 70000 cycles -> conflict_cnt saturates at 16'hFFFF.
REQ-038 Reset pulsed in the cycle after a port-0 grant -> rsp_valid0 stays 0, starve_cnt and conflict_cnt read 0.
REQ-039 Randomised req0/req1 with a scoreboard -> never both grants, every grant has exactly one matching rsp_valid one cycle later.
